// File: rtl/hack_pkg.sv
// Shared definitions for the Hack CPU core: FSM states, instruction field
// positions, jump codes and the jump condition helper.
package hack_pkg;

    typedef enum logic [1:0] {
        FETCH,
        EXEC,
        WAIT_M
    } state_t;

    localparam int unsigned TYPE_BIT = 15;
    localparam int unsigned ABIT     = 12;
    localparam int unsigned COMP_HI  = 11;
    localparam int unsigned COMP_LO  = 6;
    localparam int unsigned DEST_HI  = 5;
    localparam int unsigned DEST_LO  = 3;
    localparam int unsigned JUMP_HI  = 2;
    localparam int unsigned JUMP_LO  = 0;

    localparam logic [2:0] JNULL = 3'b000;
    localparam logic [2:0] JGT   = 3'b001;
    localparam logic [2:0] JEQ   = 3'b010;
    localparam logic [2:0] JGE   = 3'b011;
    localparam logic [2:0] JLT   = 3'b100;
    localparam logic [2:0] JNE   = 3'b101;
    localparam logic [2:0] JLE   = 3'b110;
    localparam logic [2:0] JMP   = 3'b111;

    localparam logic [14:0] RESET_PC_DEFAULT = 15'd0;

    // Each code expands (lt&ng)|(eq&zr)|(gt&~ng&~zr) for its bit pattern.
    function automatic logic jump_taken(input logic [2:0] j, input logic zr, input logic ng);
        logic t;
        t = 1'b0;
        case (j)
            JNULL: t = 1'b0;
            JGT:   t = ~ng & ~zr;
            JEQ:   t = zr;
            JGE:   t = zr | (~ng & ~zr);
            JLT:   t = ng;
            JNE:   t = ng | (~ng & ~zr);
            JLE:   t = ng | zr;
            JMP:   t = ng | zr | (~ng & ~zr);
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/alu.sv
// Hack ALU: optional zero/negate of each operand, add or and, optional
// negate of the result, plus zero and negative flags.
module alu (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        zx,
    input  logic        nx,
    input  logic        zy,
    input  logic        ny,
    input  logic        f,
    input  logic        no,
    output logic [15:0] out,
    output logic        zr,
    output logic        ng
);
    logic [15:0] x1, x2, y1, y2, o;

    always_comb begin
        x1  = zx ? '0 : x;
        x2  = nx ? ~x1 : x1;
        y1  = zy ? '0 : y;
        y2  = ny ? ~y1 : y1;
        o   = f ? (x2 + y2) : (x2 & y2);
        out = no ? ~o : o;
        zr  = (out == '0);
        ng  = out[15];
    end

endmodule

// File: rtl/hack_cpu.sv
// Hack CPU control/datapath: A, D, PC and IR registers, instruction decode,
// fetch/execute/memory-wait sequencing and jump resolution around the alu.
module hack_cpu
    import hack_pkg::*;
#(
    parameter logic [14:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    output logic [14:0] pc,
    input  logic [15:0] in_m,
    input  logic        in_m_valid,
    output logic        read_m,
    output logic [15:0] out_m,
    output logic        write_m,
    output logic [14:0] address_m
);
    state_t      state, state_nxt;
    logic [15:0] a_reg, d_reg, ir;
    logic [15:0] alu_out;
    logic        zr, ng;
    logic        is_c, a_bit;
    logic [5:0]  comp;
    logic [2:0]  dest, jump;
    logic        ir_load, a_exec, commit, jmp;

    assign is_c  = ir[TYPE_BIT];
    assign a_bit = ir[ABIT];
    assign comp  = ir[COMP_HI:COMP_LO];
    assign dest  = ir[DEST_HI:DEST_LO];
    assign jump  = ir[JUMP_HI:JUMP_LO];

    alu u_alu (
        .x   (d_reg),
        .y   (a_bit ? in_m : a_reg),
        .zx  (comp[5]),
        .nx  (comp[4]),
        .zy  (comp[3]),
        .ny  (comp[2]),
        .f   (comp[1]),
        .no  (comp[0]),
        .out (alu_out),
        .zr  (zr),
        .ng  (ng)
    );

    assign jmp       = jump_taken(jump, zr, ng);
    assign out_m     = alu_out;
    assign write_m   = commit & dest[0];
    assign address_m = a_reg[14:0];

    always_comb begin
        state_nxt = state;
        ir_load   = 1'b0;
        a_exec    = 1'b0;
        commit    = 1'b0;
        read_m    = 1'b0;
        case (state)
            FETCH: begin
                if (instr_valid) begin
                    ir_load   = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (!is_c) begin
                    a_exec    = 1'b1;
                    state_nxt = FETCH;
                end else if (a_bit) begin
                    read_m = 1'b1;
                    if (in_m_valid) begin
                        commit    = 1'b1;
                        state_nxt = FETCH;
                    end else begin
                        state_nxt = WAIT_M;
                    end
                end else begin
                    commit    = 1'b1;
                    state_nxt = FETCH;
                end
            end
            WAIT_M: begin
                read_m = 1'b1;
                if (in_m_valid) begin
                    commit    = 1'b1;
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = FETCH;
        endcase
    end

    // All commit writes sample the pre-commit A, so a jump alongside dest.A targets the old A.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
            pc    <= RESET_PC;
            a_reg <= '0;
            d_reg <= '0;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            if (ir_load) begin
                ir <= instr;
            end
            if (a_exec) begin
                a_reg <= {1'b0, ir[14:0]};
                pc    <= pc + 15'd1;
            end
            if (commit) begin
                if (dest[2]) a_reg <= alu_out;
                if (dest[1]) d_reg <= alu_out;
                pc <= jmp ? a_reg[14:0] : pc + 15'd1;
            end
        end
    end

endmodule

// File: tb/tb_hack_cpu.sv
// Directed-vector bench for hack_cpu: runs short programs through a fetch/memory
// handshake driver and checks pc, RAM write strobes and read requests.
module tb_hack_cpu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic [14:0] pc;
    logic [15:0] in_m = '0;
    logic        in_m_valid = 1'b0;
    logic        read_m;
    logic [15:0] out_m;
    logic        write_m;
    logic [14:0] address_m;

    int errors = 0;
    int checks = 0;

    hack_cpu #(.RESET_PC(15'd0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .in_m        (in_m),
        .in_m_valid  (in_m_valid),
        .read_m      (read_m),
        .out_m       (out_m),
        .write_m     (write_m),
        .address_m   (address_m)
    );

    always #5 clk = ~clk;

    // Drives one instruction from a negedge; memory data becomes valid after lat wait cycles.
    task automatic run(input logic [15:0] ins, input logic [15:0] mdata, input int lat,
                       output logic [14:0] fpc, output int rc, output int wc,
                       output logic [15:0] wd, output logic [14:0] wa);
        logic needs_m;
        int   n;
        needs_m = ins[15] & ins[12];
        n  = needs_m ? lat + 1 : 1;
        rc = 0; wc = 0; wd = '0; wa = '0;
        instr = ins; instr_valid = 1'b1; in_m_valid = 1'b0;
        #1;
        fpc = pc;
        if (read_m) rc++;
        if (write_m) wc++;
        @(posedge clk); @(negedge clk);
        instr_valid = 1'b0; instr = '0;
        for (int i = 0; i < n; i++) begin
            in_m = mdata;
            in_m_valid = needs_m && (i == lat);
            #1;
            if (read_m) rc++;
            if (write_m) begin wc++; wd = out_m; wa = address_m; end
            @(posedge clk); @(negedge clk);
        end
        in_m_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        checks++; if (pc !== 15'd0) begin errors++; $display("FAIL reset_pc: got %h want %h", pc, 15'd0); end
        checks++; if (read_m !== 1'b0) begin errors++; $display("FAIL reset_read_m: got %b want 0", read_m); end
        checks++; if (write_m !== 1'b0) begin errors++; $display("FAIL reset_write_m: got %b want 0", write_m); end
        checks++; if (address_m !== 15'd0) begin errors++; $display("FAIL reset_a: got %h want %h", address_m, 15'd0); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_a_plus_1();
        logic [14:0] fpc, wa; logic [15:0] wd; int rc, wc;
        run(16'h0007, '0, 0, fpc, rc, wc, wd, wa);
        checks++; if (wc !== 0) begin errors++; $display("FAIL ainstr_write: got %0d want 0", wc); end
        run(16'hEDD0, '0, 0, fpc, rc, wc, wd, wa);
        checks++; if (fpc !== 15'd1) begin errors++; $display("FAIL aplus1_fpc: got %h want %h", fpc, 15'd1); end
        checks++; if (wc !== 0 || rc !== 0) begin errors++; $display("FAIL aplus1_mem: got wc=%0d rc=%0d want 0 0", wc, rc); end
        run(16'hE308, '0, 0, fpc, rc, wc, wd, wa);
        checks++; if (fpc !== 15'd2) begin errors++; $display("FAIL aplus1_pc: got %h want %h", fpc, 15'd2); end
        checks++; if (wc !== 1 || wd !== 16'd8 || wa !== 15'd7)
            begin errors++; $display("FAIL aplus1_d: got wc=%0d d=%h addr=%h want 1 0008 0007", wc, wd, wa); end
    endtask

    task automatic test_rmw();
        logic [14:0] fpc, wa; logic [15:0] wd; int rc, wc;
        run(16'h0064, '0, 0, fpc, rc, wc, wd, wa);
        run(16'hFDC8, 16'd41, 3, fpc, rc, wc, wd, wa);
        checks++; if (fpc !== 15'd4) begin errors++; $display("FAIL rmw_fpc: got %h want %h", fpc, 15'd4); end
        checks++; if (rc !== 4) begin errors++; $display("FAIL rmw_read_cycles: got %0d want 4", rc); end
        checks++; if (wc !== 1) begin errors++; $display("FAIL rmw_write_pulses: got %0d want 1", wc); end
        checks++; if (wa !== 15'd100 || wd !== 16'd42)
            begin errors++; $display("FAIL rmw_data: got addr=%0d data=%0d want 100 42", wa, wd); end
    endtask

    task automatic test_jump();
        logic [14:0] fpc, wa; logic [15:0] wd; int rc, wc;
        run(16'hEA90, '0, 0, fpc, rc, wc, wd, wa);
        checks++; if (fpc !== 15'd5) begin errors++; $display("FAIL rmw_length: got %h want %h", fpc, 15'd5); end
        run(16'h0014, '0, 0, fpc, rc, wc, wd, wa);
        run(16'hE302, '0, 0, fpc, rc, wc, wd, wa);
        run(16'h0005, '0, 0, fpc, rc, wc, wd, wa);
        checks++; if (fpc !== 15'd20) begin errors++; $display("FAIL jeq_taken: got %h want %h", fpc, 15'd20); end
        run(16'hEC10, '0, 0, fpc, rc, wc, wd, wa);
        run(16'h0014, '0, 0, fpc, rc, wc, wd, wa);
        run(16'hE302, '0, 0, fpc, rc, wc, wd, wa);
        run(16'h7FFF, '0, 0, fpc, rc, wc, wd, wa);
        checks++; if (fpc !== 15'd24) begin errors++; $display("FAIL jeq_not_taken: got %h want %h", fpc, 15'd24); end
        run(16'hEC10, '0, 0, fpc, rc, wc, wd, wa);
        run(16'hE7D0, '0, 0, fpc, rc, wc, wd, wa);
        run(16'h0014, '0, 0, fpc, rc, wc, wd, wa);
        run(16'hE304, '0, 0, fpc, rc, wc, wd, wa);
        checks++; if (fpc !== 15'd28) begin errors++; $display("FAIL jlt_fpc: got %h want %h", fpc, 15'd28); end
    endtask

    task automatic test_jump_dest_a();
        logic [14:0] fpc, wa; logic [15:0] wd; int rc, wc;
        run(16'h001E, '0, 0, fpc, rc, wc, wd, wa);
        checks++; if (fpc !== 15'd20) begin errors++; $display("FAIL jlt_taken: got %h want %h", fpc, 15'd20); end
        run(16'hEEA7, '0, 0, fpc, rc, wc, wd, wa);
        run(16'hE308, '0, 0, fpc, rc, wc, wd, wa);
        checks++; if (fpc !== 15'd30) begin errors++; $display("FAIL jmp_old_a: got %h want %h", fpc, 15'd30); end
        checks++; if (wa !== 15'h7FFF || wd !== 16'h8000)
            begin errors++; $display("FAIL jmp_dest_a: got addr=%h d=%h want 7fff 8000", wa, wd); end
    endtask

    task automatic test_fetch_stall();
        logic [14:0] fpc, wa; logic [15:0] wd; int rc, wc;
        int bad;
        bad = 0;
        instr = 16'hEE88; instr_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (pc !== 15'd31 || read_m !== 1'b0 || write_m !== 1'b0) bad++;
            @(posedge clk); @(negedge clk);
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL stall_hold: got %0d bad cycles want 0", bad); end
        run(16'hEE88, '0, 0, fpc, rc, wc, wd, wa);
        checks++; if (fpc !== 15'd31 || wc !== 1 || wd !== 16'hFFFF || wa !== 15'h7FFF)
            begin errors++; $display("FAIL stall_resume: got pc=%h wc=%0d d=%h addr=%h want 001f 1 ffff 7fff", fpc, wc, wd, wa); end
    endtask

    task automatic test_pc_wrap();
        logic [14:0] fpc, wa; logic [15:0] wd; int rc, wc;
        run(16'h7FFF, '0, 0, fpc, rc, wc, wd, wa);
        run(16'hEA87, '0, 0, fpc, rc, wc, wd, wa);
        run(16'h0005, '0, 0, fpc, rc, wc, wd, wa);
        checks++; if (fpc !== 15'h7FFF) begin errors++; $display("FAIL wrap_top: got %h want %h", fpc, 15'h7FFF); end
        run(16'hEC10, '0, 0, fpc, rc, wc, wd, wa);
        checks++; if (fpc !== 15'd0) begin errors++; $display("FAIL wrap_zero: got %h want %h", fpc, 15'd0); end
        run(16'hE308, '0, 0, fpc, rc, wc, wd, wa);
        checks++; if (fpc !== 15'd1 || wd !== 16'd5 || wa !== 15'd5)
            begin errors++; $display("FAIL wrap_exec: got pc=%h d=%h addr=%h want 0001 0005 0005", fpc, wd, wa); end
    endtask

    task automatic test_reset_mid_wait();
        logic [14:0] fpc, wa; logic [15:0] wd; int rc, wc;
        run(16'h0064, '0, 0, fpc, rc, wc, wd, wa);
        instr = 16'hFDC8; instr_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        instr_valid = 1'b0;
        #1;
        checks++; if (read_m !== 1'b1) begin errors++; $display("FAIL rst_exec_read: got %b want 1", read_m); end
        @(posedge clk); @(negedge clk);
        in_m = 16'd41; in_m_valid = 1'b1;
        #1;
        checks++; if (write_m !== 1'b1) begin errors++; $display("FAIL rst_pending_write: got %b want 1", write_m); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (write_m !== 1'b0 || read_m !== 1'b0)
            begin errors++; $display("FAIL rst_async_drop: got w=%b r=%b want 0 0", write_m, read_m); end
        checks++; if (pc !== 15'd0 || address_m !== 15'd0)
            begin errors++; $display("FAIL rst_async_regs: got pc=%h a=%h want 0000 0000", pc, address_m); end
        in_m_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run(16'hE308, '0, 0, fpc, rc, wc, wd, wa);
        checks++; if (fpc !== 15'd0 || wc !== 1 || wd !== 16'd0 || wa !== 15'd0)
            begin errors++; $display("FAIL rst_after: got pc=%h wc=%0d d=%h addr=%h want 0000 1 0000 0000", fpc, wc, wd, wa); end
    endtask

    initial begin
        test_reset();
        test_a_plus_1();
        test_rmw();
        test_jump();
        test_jump_dest_a();
        test_fetch_stall();
        test_pc_wrap();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
